// File: rtl/poly_tone_pkg.sv
// poly_tone_pkg: shared frame/slot constants and the mixer saturation helper.
// ENVELOPE_EN (optional macro) enables per-voice decaying envelopes; the
// envelope period constant lives here either way.
package poly_tone_pkg;
    localparam int FRAME_CLKS        = 512;
    localparam int SLOT_BITS         = 32;
    localparam int ENV_PERIOD_FRAMES = 256;
    localparam int ACC_W             = 40;   // wide enough for 8 voices of 31-bit samples

    // Add at full width, then clip to a signed w-bit range.
    function automatic logic signed [ACC_W-1:0] sat_add(
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] b,
        input int                      w
    );
        logic signed [ACC_W-1:0] s, hi;
        s  = a + b;
        hi = $signed((ACC_W'(1) << (w - 1)) - ACC_W'(1));
        if (s > hi)
            return hi;
        else if (s < ~hi)
            return ~hi;
        return s;
    endfunction
endpackage

// File: rtl/poly_tone_i2s_if.sv
// poly_tone_i2s_if: sequencer-side control bus (note writes, pan, volume, mute).
interface poly_tone_i2s_if #(
    parameter int NUM_VOICES = 4,
    parameter int DIV_W      = 22
);
    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    logic                  note_we;
    logic [IDX_W-1:0]      note_idx;
    logic [DIV_W-1:0]      note_div;
    logic [NUM_VOICES-1:0] pan_l;
    logic [NUM_VOICES-1:0] pan_r;
    logic [2:0]            vol;
    logic                  mute;

    modport master (output note_we, note_idx, note_div, pan_l, pan_r, vol, mute);
    modport slave  (input  note_we, note_idx, note_div, pan_l, pan_r, vol, mute);
endinterface

// File: rtl/poly_tone_i2s_tone_voice.sv
// tone_voice: one square-wave voice (half-period divider + phase) producing a
// signed contribution of +/-(AMP>>vol). With ENVELOPE_EN a 4-bit envelope
// scales the amplitude and decays on env_step.
module tone_voice
    import poly_tone_pkg::*;
#(
    parameter int                  DIV_W    = 22,
    parameter int                  SAMPLE_W = 16,
    parameter logic [SAMPLE_W-1:0] AMP      = 16'h1000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [DIV_W-1:0]           div_in,
    input  logic [2:0]                 vol,
`ifdef ENVELOPE_EN
    input  logic                       env_step,
`endif
    output logic signed [SAMPLE_W-1:0] contrib
);
    logic [DIV_W-1:0]           div, cnt;
    logic                       phase;
    logic signed [SAMPLE_W-1:0] amp;

    // Divider: a write restarts the voice and takes priority over a wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            div   <= '0;
            cnt   <= '0;
            phase <= 1'b0;
        end else if (we) begin
            div   <= div_in;
            cnt   <= '0;
            phase <= 1'b0;
        end else if (div == '0) begin
            cnt   <= '0;
        end else if (cnt == div - DIV_W'(1)) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + DIV_W'(1);
        end
    end

`ifdef ENVELOPE_EN
    logic [3:0]          env;
    logic [SAMPLE_W-1:0] base;

    // Envelope: full on a sounding write, decays one step per env period.
    always_ff @(posedge clk) begin
        if (rst)
            env <= '0;
        else if (we)
            env <= (div_in != '0) ? 4'd15 : 4'd0;
        else if (env_step && env != 4'd0)
            env <= env - 4'd1;
    end

    assign base = AMP >> vol;
    assign amp  = SAMPLE_W'((base >> 4) * {{(SAMPLE_W-4){1'b0}}, env});
`else
    assign amp  = AMP >> vol;
`endif

    assign contrib = (div == '0) ? '0 : (phase ? -amp : amp);
endmodule

// File: rtl/poly_tone_i2s.sv
// poly_tone_i2s: NUM_VOICES square-wave voices, per-voice pan, saturating
// stereo mixer and I2S serializer, all timed from one 512-clk frame counter.
// ENVELOPE_EN (optional macro) adds decaying per-voice envelopes.
module poly_tone_i2s
    import poly_tone_pkg::*;
#(
    parameter int                  NUM_VOICES = 4,
    parameter int                  DIV_W      = 22,
    parameter int                  SAMPLE_W   = 16,
    parameter logic [SAMPLE_W-1:0] AMP        = 16'h1000
) (
    input  logic             clk,
    input  logic             rst,
    poly_tone_i2s_if.slave   ctl,
    output logic             audio_mclk,
    output logic             audio_lrck,
    output logic             audio_sck,
    output logic             audio_sdin,
    output logic             frame_tick
);
    localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int FCNT_W = $clog2(FRAME_CLKS);
    localparam int SLOT_W = $clog2(SLOT_BITS);

    logic [FCNT_W-1:0]                    fcnt;
    logic [NUM_VOICES-1:0]                we_v;
    logic [NUM_VOICES-1:0][SAMPLE_W-1:0]  contrib;
    logic signed [ACC_W-1:0]              acc_l, acc_r;
    logic [SAMPLE_W-1:0]                  mix_l, mix_r, sh_l, sh_r, smp;
    logic [SLOT_W:0]                      nslot;   // {channel, bit} of the next sck period
    logic                                 nbit;

    assign frame_tick = (fcnt == FCNT_W'(FRAME_CLKS - 1));
    assign audio_mclk = fcnt[1];
    assign audio_sck  = fcnt[2];
    assign audio_lrck = fcnt[8];

    // Free-running frame counter; reset restarts at left slot, bit 0.
    always_ff @(posedge clk) begin
        if (rst) fcnt <= '0;
        else     fcnt <= fcnt + FCNT_W'(1);
    end

`ifdef ENVELOPE_EN
    logic [7:0] env_div;
    logic       env_step;

    assign env_step = frame_tick && (env_div == 8'(ENV_PERIOD_FRAMES - 1));

    // Shared frame-tick divider pacing every voice's envelope decay.
    always_ff @(posedge clk) begin
        if (rst)             env_div <= '0;
        else if (frame_tick) env_div <= env_div + 8'd1;
    end
`endif

    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
        // Out-of-range indices match no voice, so such writes fall away.
        assign we_v[i] = ctl.note_we && (ctl.note_idx == IDX_W'(i));

        tone_voice #(.DIV_W(DIV_W), .SAMPLE_W(SAMPLE_W), .AMP(AMP)) u_voice (
            .clk      (clk),
            .rst      (rst),
            .we       (we_v[i]),
            .div_in   (ctl.note_div),
            .vol      (ctl.vol),
`ifdef ENVELOPE_EN
            .env_step (env_step),
`endif
            .contrib  (contrib[i])
        );
    end

    // Full-width panned sums, sign-extended per voice.
    always_comb begin
        acc_l = '0;
        acc_r = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (ctl.pan_l[i]) acc_l += {{(ACC_W-SAMPLE_W){contrib[i][SAMPLE_W-1]}}, contrib[i]};
            if (ctl.pan_r[i]) acc_r += {{(ACC_W-SAMPLE_W){contrib[i][SAMPLE_W-1]}}, contrib[i]};
        end
    end

    // Registered saturating mix, then frame-boundary capture into the shadows.
    always_ff @(posedge clk) begin
        if (rst) begin
            mix_l <= '0;
            mix_r <= '0;
            sh_l  <= '0;
            sh_r  <= '0;
        end else begin
            mix_l <= SAMPLE_W'(sat_add(acc_l, '0, SAMPLE_W));
            mix_r <= SAMPLE_W'(sat_add(acc_r, '0, SAMPLE_W));
            if (frame_tick) begin
                sh_l <= ctl.mute ? '0 : mix_l;
                sh_r <= ctl.mute ? '0 : mix_r;
            end
        end
    end

    // Select the bit for the upcoming sck period: bit 0 is the I2S delay slot.
    always_comb begin
        nslot = fcnt[FCNT_W-1:3] + (SLOT_W+1)'(1);
        smp   = nslot[SLOT_W] ? sh_r : sh_l;
        nbit  = 1'b0;
        for (int k = 1; k <= SAMPLE_W; k++)
            if (nslot[SLOT_W-1:0] == SLOT_W'(k)) nbit = smp[SAMPLE_W-k];
    end

    // sdin changes only at the end of an sck period (sck falling edge).
    always_ff @(posedge clk) begin
        if (rst)                  audio_sdin <= 1'b0;
        else if (fcnt[2:0] == 3'd7) audio_sdin <= nbit;
    end
endmodule
